// File: rtl/board_io_if.sv
// Board I/O bundle between the CPU top and the board controller:
// mode select, step button, display value, CPU enable and 7-seg drive.
interface board_io_if #(
    parameter int DIGITS = 4
);
    logic [1:0]          selclk;
    logic                button;
    logic [4*DIGITS-1:0] value;
    logic                cpu_en;
    logic [DIGITS-1:0]   an;
    logic [7:0]          cat;

    modport master (
        output selclk, button, value,
        input  cpu_en, an, cat
    );

    modport slave (
        input  selclk, button, value,
        output cpu_en, an, cat
    );
endinterface

// File: rtl/board_io_ctrl.sv
// Board I/O controller: CPU clock-enable generation (free-run, divided,
// debounced single-step, halt) and a multiplexed hex 7-segment display.
module board_io_ctrl #(
    parameter int DIGITS = 4,
    parameter int DIV_N  = 50000000,
    parameter int SCAN_N = 100000,
    parameter int DEB_N  = 1000000
) (
    input logic       sysclk,
    input logic       rst,
    board_io_if.slave io
);
    localparam int DIV_W  = (DIV_N  > 2) ? $clog2(DIV_N)  : 1;
    localparam int SCAN_W = (SCAN_N > 2) ? $clog2(SCAN_N) : 1;
    localparam int DEB_W  = (DEB_N  > 2) ? $clog2(DEB_N)  : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        MODE_RUN  = 2'd0,
        MODE_DIV  = 2'd1,
        MODE_STEP = 2'd2,
        MODE_HALT = 2'd3
    } mode_t;

    mode_t               sel_q;
    logic [DIV_W-1:0]    div_cnt;
    logic [1:0]          sync_q;
    logic                deb_state;
    logic [DEB_W-1:0]    deb_cnt;
    logic                deb_rise;
    logic [SCAN_W-1:0]   scan_cnt;
    logic [IDX_W-1:0]    dig_idx;
    logic [4*DIGITS-1:0] shadow;

    logic                mode_chg;
    logic                div_last;
    logic [3:0]          nib;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   an_nx;
    logic                dp;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
        endcase
    endfunction

    // The mode change is caught on the edge that loads sel_q, so the new
    // mode drives cpu_en exactly two cycles after selclk moves.
    always_comb begin
        mode_chg = (mode_t'(io.selclk) != sel_q);
        div_last = (div_cnt == DIV_W'(DIV_N - 1));
        nib      = '0;
        an_nx    = '1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (dig_idx == IDX_W'(i)) begin
                nib      = shadow[4*i +: 4];
                an_nx[i] = 1'b0;
            end
        end
        seg = seg7(nib);
        dp  = !((sel_q == MODE_HALT) && (dig_idx == '0));
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            sel_q     <= MODE_HALT;
            div_cnt   <= '0;
            sync_q    <= '0;
            deb_state <= 1'b0;
            deb_cnt   <= '0;
            deb_rise  <= 1'b0;
            scan_cnt  <= '0;
            dig_idx   <= '0;
            shadow    <= '0;
            io.cpu_en <= 1'b0;
            io.an     <= '1;
            io.cat    <= 8'hFF;
        end else begin
            sel_q    <= mode_t'(io.selclk);
            sync_q   <= {sync_q[0], io.button};
            deb_rise <= 1'b0;

            if (sync_q[1] == deb_state) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_W'(DEB_N - 1)) begin
                deb_state <= ~deb_state;
                deb_cnt   <= '0;
                deb_rise  <= ~deb_state;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end

            // deb_rise is a single-cycle pulse, so edges outside step mode vanish.
            if (mode_chg) begin
                div_cnt   <= '0;
                io.cpu_en <= 1'b0;
            end else begin
                div_cnt <= div_last ? '0 : div_cnt + DIV_W'(1);
                unique case (sel_q)
                    MODE_RUN:  io.cpu_en <= 1'b1;
                    MODE_DIV:  io.cpu_en <= div_last;
                    MODE_STEP: io.cpu_en <= deb_rise;
                    MODE_HALT: io.cpu_en <= 1'b0;
                endcase
            end

            if ((scan_cnt == '0) && (dig_idx == '0)) begin
                shadow <= io.value;
            end
            if (scan_cnt == SCAN_W'(SCAN_N - 1)) begin
                scan_cnt <= '0;
                dig_idx  <= (dig_idx == IDX_W'(DIGITS - 1)) ? '0 : dig_idx + IDX_W'(1);
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end

            io.an  <= an_nx;
            io.cat <= {dp, seg};
        end
    end
endmodule
